// File: rtl/ddr_tx_pkg.sv
// Shared constants and helpers for the DDR transmit serializer.
// Optional statistics are enabled with DDR_TX_STATS_EN.
package ddr_tx_pkg;

  localparam int unsigned STATS_W = 32;

  function automatic int unsigned fill_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ddr_tx_serializer_out_cell.sv
// One output bit: XOR of a rising-edge and a falling-edge register.
// The clock never enters the data path.
module ddr_out_cell #(
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic rise_i,
  input  logic fall_i,
  output logic q_o
);

  logic rise_q;
  logic hold_q;
  logic fall_q;

  // Each register stores its target XOR the other, so the XOR shows the target.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= IDLE_BIT ^ fall_q;
      hold_q <= IDLE_BIT;
    end else begin
      rise_q <= rise_i ^ fall_q;
      hold_q <= fall_i;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      fall_q <= IDLE_BIT ^ rise_q;
    end else begin
      fall_q <= hold_q ^ rise_q;
    end
  end

  assign q_o = rise_q ^ fall_q;

endmodule

// File: rtl/ddr_tx_serializer.sv
// FIFO-fed DDR transmit serializer: low half on rising, high half on falling.
// Define DDR_TX_STATS_EN to add word_count and underflow_count outputs.
module ddr_tx_serializer
  import ddr_tx_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*DATA_WIDTH-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      out_en,
  input  logic                      flush,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      out_valid,
`ifdef DDR_TX_STATS_EN
  output logic [STATS_W-1:0]        word_count,
  output logic [STATS_W-1:0]        underflow_count,
`endif
  output logic [fill_w(DEPTH)-1:0]  fill_level
);

  localparam int FW = fill_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wptr_q;
  logic [AW-1:0]           rptr_q;
  logic [FW-1:0]           cnt_q;
  logic [FW-1:0]           cnt_d;
  logic                    valid_q;
  logic                    push;
  logic                    pop;
  logic                    pop_go;
  logic [2*DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0]   rise_d;
  logic [DATA_WIDTH-1:0]   fall_d;

  assign in_ready = (cnt_q != FW'(DEPTH));
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = out_en & (cnt_q != '0) & ~flush;
  assign pop_go   = pop & ~rst;
  assign head     = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + FW'(1);
      2'b01:   cnt_d = cnt_q - FW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q   <= cnt_d;
      valid_q <= pop;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wptr_q] <= in_data;
  end

  assign rise_d = pop_go ? head[DATA_WIDTH-1:0] : IDLE_VALUE;
  assign fall_d = pop_go ? head[2*DATA_WIDTH-1:DATA_WIDTH] : IDLE_VALUE;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_cell
    ddr_out_cell #(
      .IDLE_BIT (IDLE_VALUE[i])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .rise_i (rise_d[i]),
      .fall_i (fall_d[i]),
      .q_o    (data_out[i])
    );
  end

  assign out_valid  = valid_q;
  assign fill_level = cnt_q;

`ifdef DDR_TX_STATS_EN
  logic [STATS_W-1:0] wc_q;
  logic [STATS_W-1:0] uf_q;

  // Flush leaves the statistics alone; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      wc_q <= '0;
      uf_q <= '0;
    end else begin
      if (pop && wc_q != '1) wc_q <= wc_q + 1'b1;
      if (out_en && cnt_q == '0 && uf_q != '1) uf_q <= uf_q + 1'b1;
    end
  end

  assign word_count      = wc_q;
  assign underflow_count = uf_q;
`endif

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Directed vector bench for ddr_tx_serializer (DATA_WIDTH=8, DEPTH=4).
// Stats checks are compiled in when DDR_TX_STATS_EN is defined.
module tb_ddr_tx_serializer;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [15:0] din;
    logic        oe;
    logic        ev;
    logic [7:0]  er;
    logic [7:0]  ef;
    logic [2:0]  fill;
    logic        rdy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_en = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  data_out;
  logic        out_valid;
  logic [2:0]  fill_level;
`ifdef DDR_TX_STATS_EN
  logic [31:0] word_count;
  logic [31:0] underflow_count;
  int unsigned m_wc = 0;
  int unsigned m_uf = 0;
`endif

  int checks = 0;
  int errors = 0;
  int step   = 0;
  logic [2:0] prev_fill = '0;
  vec_t tbl [32];

  always #5 clk = ~clk;

  ddr_tx_serializer #(
    .DATA_WIDTH (8),
    .DEPTH      (4),
    .IDLE_VALUE (8'h5A)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_en          (out_en),
    .flush           (flush),
    .data_out        (data_out),
    .out_valid       (out_valid),
`ifdef DDR_TX_STATS_EN
    .word_count      (word_count),
    .underflow_count (underflow_count),
`endif
    .fill_level      (fill_level)
  );

  function automatic vec_t mk(
    input logic r, input logic f, input logic iv,
    input logic [15:0] d, input logic oe, input logic ev,
    input logic [7:0] er, input logic [7:0] ef,
    input logic [2:0] fl, input logic rdy);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.din = d; v.oe = oe;
    v.ev = ev; v.er = er; v.ef = ef; v.fill = fl; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %0h expected %0h",
               step, nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    rst = v.rst; flush = v.flush; in_valid = v.iv;
    in_data = v.din; out_en = v.oe;
`ifdef DDR_TX_STATS_EN
    if (v.rst) begin
      m_wc = 0; m_uf = 0;
    end else begin
      if (v.ev) m_wc++;
      if (v.oe && prev_fill == 3'd0) m_uf++;
    end
`endif
    @(posedge clk); #2;
    chk("out_valid", 32'(out_valid), 32'(v.ev));
    chk("rise_half", 32'(data_out), 32'(v.er));
    chk("fill_level", 32'(fill_level), 32'(v.fill));
    chk("in_ready", 32'(in_ready), 32'(v.rdy));
`ifdef DDR_TX_STATS_EN
    chk("word_count", word_count, m_wc);
    chk("underflow_count", underflow_count, m_uf);
`endif
    @(negedge clk); #2;
    chk("fall_half", 32'(data_out), 32'(v.ef));
    prev_fill = v.fill;
    step++;
  endtask

  initial begin
    // reset, idle, single word, back-to-back
    tbl[0]  = mk(1,0,0,16'h0000,0, 0,8'h5A,8'h5A,0,1);
    tbl[1]  = mk(1,0,0,16'h0000,1, 0,8'h5A,8'h5A,0,1);
    tbl[2]  = mk(0,0,0,16'h0000,1, 0,8'h5A,8'h5A,0,1);
    tbl[3]  = mk(0,0,1,16'hBEEF,1, 0,8'h5A,8'h5A,1,1);
    tbl[4]  = mk(0,0,0,16'h0000,1, 1,8'hEF,8'hBE,0,1);
    tbl[5]  = mk(0,0,0,16'h0000,1, 0,8'h5A,8'h5A,0,1);
    tbl[6]  = mk(0,0,1,16'h0102,1, 0,8'h5A,8'h5A,1,1);
    tbl[7]  = mk(0,0,1,16'h0304,1, 1,8'h02,8'h01,1,1);
    tbl[8]  = mk(0,0,1,16'h0506,1, 1,8'h04,8'h03,1,1);
    tbl[9]  = mk(0,0,0,16'h0000,1, 1,8'h06,8'h05,0,1);
    tbl[10] = mk(0,0,0,16'h0000,1, 0,8'h5A,8'h5A,0,1);
    // fill to full, blocked fifth push, drain
    tbl[11] = mk(0,0,1,16'h1110,0, 0,8'h5A,8'h5A,1,1);
    tbl[12] = mk(0,0,1,16'h2120,0, 0,8'h5A,8'h5A,2,1);
    tbl[13] = mk(0,0,1,16'h3130,0, 0,8'h5A,8'h5A,3,1);
    tbl[14] = mk(0,0,1,16'h4140,0, 0,8'h5A,8'h5A,4,0);
    tbl[15] = mk(0,0,1,16'h5150,0, 0,8'h5A,8'h5A,4,0);
    tbl[16] = mk(0,0,1,16'h5150,1, 1,8'h10,8'h11,3,1);
    tbl[17] = mk(0,0,1,16'h5150,1, 1,8'h20,8'h21,3,1);
    tbl[18] = mk(0,0,0,16'h0000,1, 1,8'h30,8'h31,2,1);
    tbl[19] = mk(0,0,0,16'h0000,1, 1,8'h40,8'h41,1,1);
    tbl[20] = mk(0,0,0,16'h0000,1, 1,8'h50,8'h51,0,1);
    // flush with three queued plus a discarded push
    tbl[21] = mk(0,0,1,16'h0A0B,0, 0,8'h5A,8'h5A,1,1);
    tbl[22] = mk(0,0,1,16'h0C0D,0, 0,8'h5A,8'h5A,2,1);
    tbl[23] = mk(0,0,1,16'h0E0F,0, 0,8'h5A,8'h5A,3,1);
    tbl[24] = mk(0,1,1,16'h1234,1, 0,8'h5A,8'h5A,0,1);
    tbl[25] = mk(0,0,0,16'h0000,1, 0,8'h5A,8'h5A,0,1);
    // reset in the middle of a transfer
    tbl[26] = mk(0,0,1,16'h0A0B,0, 0,8'h5A,8'h5A,1,1);
    tbl[27] = mk(0,0,1,16'h0C0D,0, 0,8'h5A,8'h5A,2,1);
    tbl[28] = mk(0,0,1,16'h0E0F,0, 0,8'h5A,8'h5A,3,1);
    tbl[29] = mk(0,0,0,16'h0000,1, 1,8'h0B,8'h0A,2,1);
    tbl[30] = mk(1,0,1,16'h1234,1, 0,8'h5A,8'h5A,0,1);
    tbl[31] = mk(0,0,0,16'h0000,1, 0,8'h5A,8'h5A,0,1);

    @(negedge clk); #2;

    for (int i = 0; i <= 20; i++) run_vec(tbl[i]);

    // ten words streamed across the pointer wrap
    for (int i = 0; i <= 10; i++) begin
      logic [7:0] lo;
      logic [7:0] hi;
      logic [7:0] plo;
      logic [7:0] phi;
      lo  = 8'h60 + 8'(i);
      hi  = 8'hC0 + 8'(i);
      plo = 8'h60 + 8'(i) - 8'd1;
      phi = 8'hC0 + 8'(i) - 8'd1;
      run_vec(mk(1'b0, 1'b0, (i < 10), {hi, lo}, 1'b1,
                 (i >= 1),
                 (i >= 1) ? plo : 8'h5A,
                 (i >= 1) ? phi : 8'h5A,
                 (i < 10) ? 3'd1 : 3'd0, 1'b1));
    end

    for (int i = 21; i <= 31; i++) run_vec(tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
